led_pwm_multi: RTL and testbench
================================

// Module: led_pwm_multi
// PURPOSE
//   Multi-channel LED driver; next generation of the single-output LED blinker.
//   Drives CH_NUM LED pins from one clock, each channel with its own mode
//   (off / on / blink / breathe) and PWM brightness.
//   A single-cycle config write port lets a host or sequencer reprogram any
//   channel at run time. Sits between the board top level and the LED pins.
// PARAMETERS
//   CH_NUM     4     number of LED channels (1..16)
//   PRESCALE   41667 clk cycles per tick (>=2); ~1 ms at the 41.67 MHz board clock
//   PWM_W      8     PWM/brightness width in bits (2..12)
//   PER_W      16    blink half-period width, in ticks
//   ACTIVE_LOW 0     1: invert led_out at the pin (LED lit = 0)
// PORTS
//   clk         in   1               system clock
//   reset       in   1               asynchronous, active-high reset
//   cfg_wr      in   1               1-cycle config write strobe
//   cfg_ch      in   4               target channel index
//   cfg_mode    in   2               00 OFF, 01 ON, 10 BLINK, 11 BREATHE
//   cfg_duty    in   PWM_W           brightness for ON / BLINK
//   cfg_period  in   PER_W           BLINK half-period in ticks
//   cfg_ack     out  1               pulse: write accepted
//   cfg_err     out  1               pulse: write rejected (cfg_ch >= CH_NUM)
//   led_out     out  CH_NUM          LED drive, registered
// BEHAVIOUR
//   Reset (async assert, sync release): every channel mode=OFF, duty=0, period=0.
//     Prescaler, PWM counter, blink and ramp state = 0. cfg_ack = cfg_err = 0.
//     led_out = 0, or all-ones when ACTIVE_LOW=1.
//   Prescaler: counts 0..PRESCALE-1. tick is a 1-cycle pulse when the count wraps.
//   PWM counter pwm_cnt: free-running PWM_W bits, +1 every clk, wraps to 0.
//   Per-channel level L (PWM_W bits):
//     OFF: L=0.
//     ON: L=duty.
//     BLINK: L = phase ? duty : 0. phase toggles after (period==0 ? 1 : period) ticks.
//     BREATHE: L = ramp. ramp steps +1 per tick up to all-ones, then -1 down to 0,
//       then up again (triangle). The endpoints are held for exactly 1 tick each.
//   Output: lit = (L == all-ones) | (pwm_cnt < L). led_out[i] <= lit ^ ACTIVE_LOW,
//     registered once. L=0 means never lit; L=all-ones means always lit.
//   Config write, cycle T with cfg_wr=1:
//     - cfg_ch < CH_NUM: the channel's mode, duty and period are loaded at edge T+1.
//       Blink counter is cleared, phase=1 (on), ramp=0, direction=up.
//       cfg_ack=1 during T+1.
//     - cfg_ch >= CH_NUM: no state changes; cfg_err=1 during T+1.
//     - New config is visible on led_out at T+2 (one register stage after load).
//   Back-to-back writes: accepted every cycle. There is no busy state.
//     Two writes to the same channel: the last one wins.
//   Write on a tick cycle: the write takes priority for the addressed channel
//     (that tick does not advance it). Other channels advance normally.
//   Blink counter and ramp advance only on tick. They are independent of pwm_cnt.
//   Unused cfg_ch bits above CH_NUM range are decoded; they are not truncated.
//   Reset asserted mid-operation: all state returns to reset values immediately.
// TESTING  (sim params: PRESCALE=4, PWM_W=4, CH_NUM=4)
//   1 Reset: hold reset 5 cycles -> led_out=4'b0000, cfg_ack=0.
//     Repeat with ACTIVE_LOW=1 -> led_out=4'b1111.
//   2 ON duty: wr ch0 mode=01 duty=4 -> cfg_ack at T+1.
//     led_out[0] high exactly 4 of every 16 cycles. duty=15 -> constantly high.
//   3 BLINK: wr ch1 mode=10 duty=15 period=3 -> led_out[1] high 12 cycles, low 12,
//     repeating. period=0 -> toggles every 4 cycles (1 tick).
//   4 BREATHE: wr ch2 mode=11 -> ramp 0,1..15,14..0 per 4-cycle tick.
//     Check the high count per 16-cycle PWM window tracks the ramp.
//   5 Error/priority: wr cfg_ch=7 -> cfg_err pulse, led_out unchanged.
//     Write ch3 on a tick cycle -> ch3 phase restarts on; other channels unaffected.
//   6 Reset mid-blink: assert reset while ch1 is blinking -> led_out=0 asynchronously.
//     After release, all channels stay OFF until rewritten.

Source files
------------

// File: rtl/led_pwm_multi_if.sv
// Configuration write port of led_pwm_multi: a host-driven write strobe with
// a one-cycle-later accept/reject pulse back from the LED driver.
interface led_pwm_multi_if #(
    parameter int PWM_W = 8,
    parameter int PER_W = 16
);
    // cfg_wr is a valid-only strobe; the slave is always ready, so every cycle
    // with cfg_wr=1 is a transfer, answered next cycle by exactly one of cfg_ack/cfg_err.
    logic             cfg_wr;
    logic [3:0]       cfg_ch;
    logic [1:0]       cfg_mode;
    logic [PWM_W-1:0] cfg_duty;
    logic [PER_W-1:0] cfg_period;
    logic             cfg_ack;
    logic             cfg_err;

    modport master (
        output cfg_wr, cfg_ch, cfg_mode, cfg_duty, cfg_period,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_mode, cfg_duty, cfg_period,
        output cfg_ack, cfg_err
    );
endinterface

// File: rtl/led_pwm_multi.sv
// Multi-channel LED driver: per-channel off/on/blink/breathe mode with PWM
// brightness, reprogrammable at run time through a single-cycle write port.
module led_pwm_multi #(
    parameter int CH_NUM     = 4,
    parameter int PRESCALE   = 41667,
    parameter int PWM_W      = 8,
    parameter int PER_W      = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    led_pwm_multi_if.slave    cfg,
    output logic [CH_NUM-1:0] led_out
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PWM_W-1:0] L_MAX = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              cfg_ok;

    mode_t             mode_q    [CH_NUM];
    logic [PWM_W-1:0]  duty_q    [CH_NUM];
    logic [PER_W-1:0]  period_q  [CH_NUM];
    logic [PER_W-1:0]  blink_cnt [CH_NUM];
    logic              phase_q   [CH_NUM];
    logic [PWM_W-1:0]  ramp_q    [CH_NUM];
    logic              ramp_up   [CH_NUM];
    logic [PWM_W-1:0]  level     [CH_NUM];

    logic [CH_NUM-1:0] sel;
    logic [CH_NUM-1:0] blink_last;
    logic [CH_NUM-1:0] lit;

    assign tick   = (pre_cnt == PRE_W'(PRESCALE - 1));
    // Full 4-bit index is compared, so out-of-range channels are rejected, not aliased.
    assign cfg_ok = ({1'b0, cfg.cfg_ch} < 5'(CH_NUM));

    always_comb begin
        sel        = '0;
        blink_last = '0;
        lit        = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            level[i] = '0;
            sel[i]   = cfg.cfg_wr && (cfg.cfg_ch == 4'(i));
            // A zero period behaves as a one-tick half-period.
            blink_last[i] = (period_q[i] == '0) || (blink_cnt[i] >= period_q[i] - 1'b1);
            case (mode_q[i])
                MODE_ON:      level[i] = duty_q[i];
                MODE_BLINK:   level[i] = phase_q[i] ? duty_q[i] : '0;
                MODE_BREATHE: level[i] = ramp_q[i];
                default:      level[i] = '0;
            endcase
            lit[i] = (level[i] == L_MAX) || (pwm_cnt < level[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            cfg.cfg_ack <= 1'b0;
            cfg.cfg_err <= 1'b0;
            led_out     <= {CH_NUM{ACTIVE_LOW}};
            for (int i = 0; i < CH_NUM; i++) begin
                mode_q[i]    <= MODE_OFF;
                duty_q[i]    <= '0;
                period_q[i]  <= '0;
                blink_cnt[i] <= '0;
                phase_q[i]   <= 1'b0;
                ramp_q[i]    <= '0;
                ramp_up[i]   <= 1'b0;
            end
        end else begin
            pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
            pwm_cnt     <= pwm_cnt + 1'b1;
            cfg.cfg_ack <= cfg.cfg_wr && cfg_ok;
            cfg.cfg_err <= cfg.cfg_wr && !cfg_ok;
            led_out     <= lit ^ {CH_NUM{ACTIVE_LOW}};
            for (int i = 0; i < CH_NUM; i++) begin
                if (sel[i]) begin
                    // A write restarts the channel and wins over a coincident tick.
                    mode_q[i]    <= mode_t'(cfg.cfg_mode);
                    duty_q[i]    <= cfg.cfg_duty;
                    period_q[i]  <= cfg.cfg_period;
                    blink_cnt[i] <= '0;
                    phase_q[i]   <= 1'b1;
                    ramp_q[i]    <= '0;
                    ramp_up[i]   <= 1'b1;
                end else if (tick) begin
                    if (blink_last[i]) begin
                        blink_cnt[i] <= '0;
                        phase_q[i]   <= !phase_q[i];
                    end else begin
                        blink_cnt[i] <= blink_cnt[i] + 1'b1;
                    end
                    // Triangle ramp: direction flips on arrival at an endpoint,
                    // so each endpoint lasts exactly one tick.
                    if (ramp_up[i]) begin
                        ramp_q[i] <= ramp_q[i] + 1'b1;
                        if (ramp_q[i] == L_MAX - 1'b1) ramp_up[i] <= 1'b0;
                    end else begin
                        ramp_q[i] <= ramp_q[i] - 1'b1;
                        if (ramp_q[i] == PWM_W'(1)) ramp_up[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pwm_multi.sv
// Bench for led_pwm_multi: directed steps plus random config writes, checked
// every cycle against a tick-count/triangle arithmetic model of each channel.
module tb_led_pwm_multi;
    localparam int CH   = 4;
    localparam int PRE  = 4;
    localparam int PW   = 4;
    localparam int PERW = 16;
    localparam int LMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] led;
    logic [CH-1:0] led_al;

    led_pwm_multi_if #(.PWM_W(PW), .PER_W(PERW)) bus ();
    led_pwm_multi_if #(.PWM_W(PW), .PER_W(PERW)) bus_al ();

    led_pwm_multi #(.CH_NUM(CH), .PRESCALE(PRE), .PWM_W(PW), .PER_W(PERW), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .cfg(bus.slave), .led_out(led)
    );
    led_pwm_multi #(.CH_NUM(CH), .PRESCALE(PRE), .PWM_W(PW), .PER_W(PERW), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset), .cfg(bus_al.slave), .led_out(led_al)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: each channel keeps its config and the cycle it was loaded;
    // the level follows from how many ticks have elapsed since that load.
    int            cyc;
    int            mmode [CH];
    int            mduty [CH];
    int            mper  [CH];
    int            mk    [CH];
    int            lv;
    int            wch;
    logic [CH-1:0] exp_led;
    logic          exp_ack;
    logic          exp_err;

    function automatic int model_level(int ch, int m);
        int t;
        int eff;
        t   = m / PRE - mk[ch] / PRE;
        eff = (mper[ch] == 0) ? 1 : mper[ch];
        case (mmode[ch])
            0:       return 0;
            1:       return mduty[ch];
            2:       return ((t / eff) % 2 == 0) ? mduty[ch] : 0;
            default: begin
                t = t % (2 * LMAX);
                return (t <= LMAX) ? t : 2 * LMAX - t;
            end
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc     = 0;
            exp_led = '0;
            exp_ack = 1'b0;
            exp_err = 1'b0;
            for (int i = 0; i < CH; i++) begin
                mmode[i] = 0; mduty[i] = 0; mper[i] = 0; mk[i] = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                lv = model_level(i, cyc);
                exp_led[i] = (lv == LMAX) || ((cyc % (LMAX + 1)) < lv);
            end
            exp_ack = bus.cfg_wr && (int'(bus.cfg_ch) < CH);
            exp_err = bus.cfg_wr && (int'(bus.cfg_ch) >= CH);
            cyc++;
            if (exp_ack) begin
                wch        = int'(bus.cfg_ch);
                mmode[wch] = int'(bus.cfg_mode);
                mduty[wch] = int'(bus.cfg_duty);
                mper[wch]  = int'(bus.cfg_period);
                mk[wch]    = cyc;
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("led_out", 32'(led), 32'(exp_led));
            check("cfg_ack", 32'(bus.cfg_ack), 32'(exp_ack));
            check("cfg_err", 32'(bus.cfg_err), 32'(exp_err));
            check("led_out_active_low", 32'(led_al), 32'hF);
        end
    end

    task automatic cfg_write(input int ch, input int mode, input int duty, input int per);
        bus.cfg_wr     = 1'b1;
        bus.cfg_ch     = 4'(ch);
        bus.cfg_mode   = 2'(mode);
        bus.cfg_duty   = PW'(duty);
        bus.cfg_period = PERW'(per);
        @(negedge clk);
        bus.cfg_wr = 1'b0;
    endtask

    task automatic count_high(input int ch, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            cnt += int'(led[ch]);
        end
    endtask

    int c;

    initial begin
        reset = 1'b0;
        bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_mode = '0; bus.cfg_duty = '0; bus.cfg_period = '0;
        bus_al.cfg_wr = 1'b0; bus_al.cfg_ch = '0; bus_al.cfg_mode = '0;
        bus_al.cfg_duty = '0; bus_al.cfg_period = '0;
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // Reset values, both polarities
        repeat (5) @(negedge clk);
        check("rst_led", 32'(led), 32'h0);
        check("rst_ack", 32'(bus.cfg_ack), 32'h0);
        check("rst_led_al", 32'(led_al), 32'hF);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // ON with partial and full duty
        cfg_write(0, 1, 4, 0);
        check("on_ack", 32'(bus.cfg_ack), 32'h1);
        count_high(0, 16, c);
        check("on_duty4_high", 32'(c), 32'd4);
        cfg_write(0, 1, 15, 0);
        count_high(0, 16, c);
        check("on_duty15_high", 32'(c), 32'd16);

        // BLINK, period 3 then period 0
        cfg_write(1, 2, 15, 3);
        count_high(1, 48, c);
        check("blink_p3_high", 32'(c), 32'd24);
        cfg_write(1, 2, 15, 0);
        count_high(1, 32, c);
        check("blink_p0_high", 32'(c), 32'd16);

        // BREATHE over more than a full triangle
        cfg_write(2, 3, 0, 0);
        repeat (130) @(negedge clk);

        // Rejected channel
        cfg_write(7, 1, 15, 0);
        check("err_pulse", 32'(bus.cfg_err), 32'h1);
        check("err_no_ack", 32'(bus.cfg_ack), 32'h0);

        // Write landing on a tick cycle restarts the channel lit
        for (int w = 0; w < 2 * PRE && (cyc % PRE) != PRE - 1; w++) @(negedge clk);
        cfg_write(3, 2, 15, 1);
        count_high(3, 4, c);
        check("tick_write_on", 32'(c), 32'd4);
        @(negedge clk);
        check("tick_write_off", 32'(led[3]), 32'h0);

        // Back-to-back writes to one channel: last one wins
        cfg_write(0, 1, 2, 0);
        cfg_write(0, 1, 9, 0);
        repeat (20) @(negedge clk);

        // Random writes, including back-to-back and out-of-range channels
        repeat (300) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            else
                @(negedge clk);
        end

        // Asynchronous reset in the middle of a blink
        cfg_write(1, 2, 15, 2);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_led_al", 32'(led_al), 32'hF);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        c = 0;
        repeat (40) begin
            @(negedge clk);
            c += int'(led != '0);
        end
        check("post_rst_all_off", 32'(c), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
